uart_cmd_rx: RTL and testbench



---
 rtl/uart_cmd_rx_if.sv | 26 ++
 rtl/uart_cmd_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rx_if.sv
// Output bundle of the debug-command UART receiver.
//   master : driven by uart_cmd_rx
//   slave  : consumer side (register block, test bench)
// Signals:
//   rx_byte/rx_byte_valid : last deserialised byte, one-cycle update pulse
//   cmd_addr/cmd_data     : address/data of the last good command frame
//   cmd_wr                : one-cycle register-write strobe
//   frame_err             : one-cycle pulse, stop bit sampled low
//   chk_err               : one-cycle pulse, frame checksum mismatch
interface uart_cmd_rx_if;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_wr;
  logic       frame_err;
  logic       chk_err;

  modport master (
    output rx_byte, rx_byte_valid, cmd_addr, cmd_data, cmd_wr, frame_err, chk_err
  );

  modport slave (
    input rx_byte, rx_byte_valid, cmd_addr, cmd_data, cmd_wr, frame_err, chk_err
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// Debug-command receiver on the UART RXD pin (8N1, LSB first).
// Bytes are deserialised with a 2-FF synchroniser and mid-bit sampling, then
// parsed as 4-byte frames: 0xA5, ADDR, DATA, CHK with CHK = ADDR ^ DATA ^ 0x5A.
// A good frame produces a one-cycle cmd_wr with cmd_addr/cmd_data.
//
// Ports:
//   clk  : system clock (only clock)
//   rst  : synchronous, active-high reset
//   rxd  : asynchronous serial input, idle high
//   cmd  : uart_cmd_rx_if.master (byte, command and error outputs)
//
// Optional build macro UART_CMD_RX_TIMEOUT_EN: when defined, a parser left
// outside P_SYNC for TIMEOUT_BITS bit periods without a new byte silently
// falls back to P_SYNC. When undefined the parser waits indefinitely.
//
// RX FSM
//   state | meaning
//   IDLE  | line idle, waiting for rxd_s low
//   START | half a bit into the start bit, re-check it is still low
//   DATA  | sampling 8 data bits at mid-bit, LSB first
//   STOP  | sampling the stop bit at mid-bit
//   BREAK | stop bit was low, wait for the line to return high
// Parser FSM
//   state  | meaning
//   P_SYNC | waiting for 0xA5
//   P_ADDR | next byte is the register address
//   P_DATA | next byte is the register data
//   P_CHK  | next byte is the checksum
module uart_cmd_rx #(
  parameter int CLK_HZ       = 27000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  uart_cmd_rx_if.master cmd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  if (DIV < 4) begin : g_chk_div
    $error("uart_cmd_rx: CLK_HZ/BAUD must be at least 4");
  end
  if (TIMEOUT_BITS < 1) begin : g_chk_tmo
    $error("uart_cmd_rx: TIMEOUT_BITS must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA, P_CHK} p_state_t;

  logic          rxd_m;
  logic          rxd_s;
  rx_state_t     rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  p_state_t      p_state;
  logic [7:0]    stage_addr;
  logic [7:0]    stage_data;

`ifdef UART_CMD_RX_TIMEOUT_EN
  localparam int TMO_CYC = TIMEOUT_BITS * DIV;
  localparam int TW      = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_M1 = TW'(TMO_CYC - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m             <= 1'b1;
      rxd_s             <= 1'b1;
      rx_state          <= IDLE;
      cnt               <= '0;
      bit_cnt           <= '0;
      shift             <= '0;
      p_state           <= P_SYNC;
      stage_addr        <= '0;
      stage_data        <= '0;
      cmd.rx_byte       <= '0;
      cmd.rx_byte_valid <= 1'b0;
      cmd.cmd_addr      <= '0;
      cmd.cmd_data      <= '0;
      cmd.cmd_wr        <= 1'b0;
      cmd.frame_err     <= 1'b0;
      cmd.chk_err       <= 1'b0;
`ifdef UART_CMD_RX_TIMEOUT_EN
      tmo_cnt           <= '0;
`endif
    end else begin
      rxd_m             <= rxd;
      rxd_s             <= rxd_m;
      cmd.rx_byte_valid <= 1'b0;
      cmd.cmd_wr        <= 1'b0;
      cmd.frame_err     <= 1'b0;
      cmd.chk_err       <= 1'b0;

      // Parser reacts to the registered byte pulse, so cmd_wr/chk_err land
      // one cycle after the checksum byte's rx_byte_valid.
      if (cmd.rx_byte_valid) begin
`ifdef UART_CMD_RX_TIMEOUT_EN
        tmo_cnt <= TMO_M1;
`endif
        case (p_state)
          P_SYNC: if (cmd.rx_byte == 8'hA5) p_state <= P_ADDR;
          P_ADDR: begin
            stage_addr <= cmd.rx_byte;
            p_state    <= P_DATA;
          end
          P_DATA: begin
            stage_data <= cmd.rx_byte;
            p_state    <= P_CHK;
          end
          P_CHK: begin
            if (cmd.rx_byte == (stage_addr ^ stage_data ^ 8'h5A)) begin
              cmd.cmd_addr <= stage_addr;
              cmd.cmd_data <= stage_data;
              cmd.cmd_wr   <= 1'b1;
            end else begin
              cmd.chk_err  <= 1'b1;
            end
            p_state <= P_SYNC;
          end
          default: p_state <= P_SYNC;
        endcase
      end
`ifdef UART_CMD_RX_TIMEOUT_EN
      else if (p_state != P_SYNC) begin
        if (tmo_cnt == '0) p_state <= P_SYNC;
        else               tmo_cnt <= tmo_cnt - 1'b1;
      end
`endif

      case (rx_state)
        IDLE: begin
          if (!rxd_s) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            // A start bit gone high by mid-bit is a glitch.
            rx_state <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shift <= {rxd_s, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt  <= '0;
              rx_state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            // Leaving at mid-stop-bit lets back-to-back bytes through.
            if (rxd_s) begin
              cmd.rx_byte       <= shift;
              cmd.rx_byte_valid <= 1'b1;
              rx_state          <= IDLE;
            end else begin
              cmd.frame_err <= 1'b1;
              p_state       <= P_SYNC;
              rx_state      <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxd_s) begin
            cnt      <= '0;
            rx_state <= IDLE;
          end
        end
        default: begin
          cnt      <= '0;
          bit_cnt  <= '0;
          rx_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;
  localparam int CLK_HZ       = 1600;
  localparam int BAUD         = 100;
  localparam int DIV          = 16;
  localparam int TIMEOUT_BITS = 20;
  // rxd falling edge -> 2 sync flops -> idle detect -> half bit -> 8 bits -> mid stop
  localparam int LAT          = 3 + DIV / 2 + 9 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  uart_cmd_rx_if bus ();

  uart_cmd_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .cmd(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Scheduled expectations keyed by cycle number
  bit         exp_valid [int];
  bit         exp_wr    [int];
  bit         exp_chk   [int];
  bit         exp_ferr  [int];
  logic [7:0] upd_byte  [int];
  logic [7:0] upd_addr  [int];
  logic [7:0] upd_data  [int];

  logic [7:0] cur_byte = 8'h00;
  logic [7:0] cur_addr = 8'h00;
  logic [7:0] cur_data = 8'h00;

  // Frame model: position in frame, collected bytes, time of last byte
  int         pos = 0;
  logic [7:0] fb [4];
  int         last_v = 0;

  int n_valid = 0, n_wr = 0, n_chk = 0, n_ferr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int v);
    exp_valid[v] = 1'b1;
    upd_byte[v]  = b;
`ifdef UART_CMD_RX_TIMEOUT_EN
    if (pos != 0 && (v - last_v) > TIMEOUT_BITS * DIV) pos = 0;
`endif
    last_v = v;
    if (pos == 0) begin
      if (b == 8'hA5) pos = 1;
    end else begin
      fb[pos] = b;
      if (pos == 3) begin
        if (fb[3] == (fb[1] ^ fb[2] ^ 8'h5A)) begin
          exp_wr[v + 1]   = 1'b1;
          upd_addr[v + 1] = fb[1];
          upd_data[v + 1] = fb[2];
        end else begin
          exp_chk[v + 1] = 1'b1;
        end
        pos = 0;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    int v;
    v = cyc + LAT;
    if (stop_ok) model_byte(b, v);
    else begin
      exp_ferr[v] = 1'b1;
      pos = 0;
    end
    rxd = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(DIV);
    end
    rxd = stop_ok;
    wait_cyc(DIV);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (upd_byte.exists(cyc)) cur_byte = upd_byte[cyc];
      if (upd_addr.exists(cyc)) cur_addr = upd_addr[cyc];
      if (upd_data.exists(cyc)) cur_data = upd_data[cyc];
      chk("rx_byte_valid", 32'(bus.rx_byte_valid), 32'(exp_valid.exists(cyc)));
      chk("cmd_wr", 32'(bus.cmd_wr), 32'(exp_wr.exists(cyc)));
      chk("chk_err", 32'(bus.chk_err), 32'(exp_chk.exists(cyc)));
      chk("frame_err", 32'(bus.frame_err), 32'(exp_ferr.exists(cyc)));
      chk("rx_byte", 32'(bus.rx_byte), 32'(cur_byte));
      chk("cmd_addr", 32'(bus.cmd_addr), 32'(cur_addr));
      chk("cmd_data", 32'(bus.cmd_data), 32'(cur_data));
      if (bus.rx_byte_valid === 1'b1) n_valid++;
      if (bus.cmd_wr === 1'b1)        n_wr++;
      if (bus.chk_err === 1'b1)       n_chk++;
      if (bus.frame_err === 1'b1)     n_ferr++;
    end
  end

  initial begin
    int v0, w0, c0, f0;
    wait_cyc(3);
    rst = 1'b0;
    chk("reset_rx_byte", 32'(bus.rx_byte), 32'h00);
    chk("reset_cmd_addr", 32'(bus.cmd_addr), 32'h00);
    chk("reset_cmd_data", 32'(bus.cmd_data), 32'h00);
    chk("reset_pulses", 32'({bus.rx_byte_valid, bus.cmd_wr, bus.chk_err, bus.frame_err}), 32'h0);
    wait_cyc(20);

    // 1: good frame back-to-back
    v0 = n_valid; w0 = n_wr;
    send_frame(8'h10, 8'h3C, 8'h76);
    wait_cyc(4);
    chk("t1_valid_count", 32'(n_valid - v0), 32'd4);
    chk("t1_wr_count", 32'(n_wr - w0), 32'd1);
    chk("t1_addr", 32'(bus.cmd_addr), 32'h10);
    chk("t1_data", 32'(bus.cmd_data), 32'h3C);
    chk("t1_model_addr", 32'(cur_addr), 32'h10);

    // 2: bad checksum, then a good frame
    c0 = n_chk; w0 = n_wr;
    send_frame(8'h10, 8'h3C, 8'h77);
    wait_cyc(4);
    chk("t2_chk_count", 32'(n_chk - c0), 32'd1);
    chk("t2_wr_count", 32'(n_wr - w0), 32'd0);
    chk("t2_addr_kept", 32'(bus.cmd_addr), 32'h10);
    chk("t2_data_kept", 32'(bus.cmd_data), 32'h3C);
    send_frame(8'h20, 8'h01, 8'h7B);
    wait_cyc(4);
    chk("t2_wr_count2", 32'(n_wr - w0), 32'd1);
    chk("t2_addr", 32'(bus.cmd_addr), 32'h20);
    chk("t2_data", 32'(bus.cmd_data), 32'h01);

    // 2b: junk before sync, 0xA5 as payload is data
    w0 = n_wr;
    send_byte(8'h33);
    send_frame(8'hA5, 8'hA5, 8'h5A);
    wait_cyc(4);
    chk("t2b_wr_count", 32'(n_wr - w0), 32'd1);
    chk("t2b_addr", 32'(bus.cmd_addr), 32'hA5);
    chk("t2b_data", 32'(bus.cmd_data), 32'hA5);

    // 3: short low glitch, then a byte
    v0 = n_valid; f0 = n_ferr;
    rxd = 1'b0;
    wait_cyc(4);
    rxd = 1'b1;
    wait_cyc(30);
    chk("t3_glitch_valid", 32'(n_valid - v0), 32'd0);
    send_byte(8'h55);
    wait_cyc(4);
    chk("t3_valid_count", 32'(n_valid - v0), 32'd1);
    chk("t3_ferr_count", 32'(n_ferr - f0), 32'd0);
    chk("t3_rx_byte", 32'(bus.rx_byte), 32'h55);

    // 4: framing error with held-low line, then a headless frame
    wait_cyc(20);
    f0 = n_ferr; w0 = n_wr;
    send_byte(8'hA5);
    send_byte(8'h00, 1'b0);
    wait_cyc(100);
    rxd = 1'b1;
    wait_cyc(30);
    chk("t4_ferr_count", 32'(n_ferr - f0), 32'd1);
    v0 = n_valid;
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h76);
    wait_cyc(4);
    chk("t4_valid_count", 32'(n_valid - v0), 32'd3);
    chk("t4_wr_count", 32'(n_wr - w0), 32'd0);

    // 5: reset in the middle of data bit 4
    wait_cyc(20);
    rxd = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      wait_cyc(DIV);
    end
    wait_cyc(DIV / 2);
    upd_byte[cyc + 1] = 8'h00;
    upd_addr[cyc + 1] = 8'h00;
    upd_data[cyc + 1] = 8'h00;
    pos = 0;
    rst = 1'b1;
    rxd = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("t5_rx_byte", 32'(bus.rx_byte), 32'h00);
    chk("t5_cmd_addr", 32'(bus.cmd_addr), 32'h00);
    chk("t5_cmd_data", 32'(bus.cmd_data), 32'h00);
    chk("t5_pulses", 32'({bus.rx_byte_valid, bus.cmd_wr, bus.chk_err, bus.frame_err}), 32'h0);
    wait_cyc(20);
    w0 = n_wr;
    send_frame(8'h10, 8'h3C, 8'h76);
    wait_cyc(4);
    chk("t5_wr_count", 32'(n_wr - w0), 32'd1);
    chk("t5_addr", 32'(bus.cmd_addr), 32'h10);

    // 6: long gap inside a frame
    wait_cyc(20);
    w0 = n_wr;
    send_byte(8'hA5);
    send_byte(8'h10);
    wait_cyc(21 * DIV);
    send_byte(8'h3C);
    send_byte(8'h76);
    wait_cyc(4);
`ifdef UART_CMD_RX_TIMEOUT_EN
    chk("t6_wr_count", 32'(n_wr - w0), 32'd0);
`else
    chk("t6_wr_count", 32'(n_wr - w0), 32'd1);
    chk("t6_addr", 32'(bus.cmd_addr), 32'h10);
    chk("t6_data", 32'(bus.cmd_data), 32'h3C);
`endif

    wait_cyc(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
